// File: rtl/pb_pkg.sv
// Shared constants and FSM encoding for the PB frame sequencer and its length lookup.
package pb_pkg;

  localparam logic [1:0] PB16   = 2'h0;
  localparam logic [1:0] PB136  = 2'h1;
  localparam logic [1:0] PB520  = 2'h2;
  localparam logic [1:0] PBCUST = 2'h3;

  localparam int unsigned LEN_PB16_DEF  = 64;
  localparam int unsigned LEN_PB136_DEF = 544;
  localparam int unsigned LEN_PB520_DEF = 2080;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    START,
    WAIT,
    DONE
  } pb_state_t;

endpackage

// File: rtl/pb_len_lut.sv
// Combinational PB size code to interleaver length map, including custom-length validation.
module pb_len_lut
  import pb_pkg::*;
#(
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned LEN_PB16  = LEN_PB16_DEF,
  parameter int unsigned LEN_PB136 = LEN_PB136_DEF,
  parameter int unsigned LEN_PB520 = LEN_PB520_DEF
) (
  input  logic [1:0]       code,
  input  logic [LEN_W-1:0] cfg_len,
  output logic [LEN_W-1:0] len,
  output logic             valid
);

  // Refuse to elaborate rather than silently truncate a fixed length.
  if (LEN_PB520 >= (32'd1 << LEN_W)) begin : g_len_check
    $error("LEN_PB520 does not fit in LEN_W bits");
  end

  always_comb begin
    len   = '0;
    valid = 1'b1;
    case (code)
      PB16:   len = LEN_W'(LEN_PB16);
      PB136:  len = LEN_W'(LEN_PB136);
      PB520:  len = LEN_W'(LEN_PB520);
      PBCUST: begin
        len   = cfg_len;
        // Custom L must be non-zero and a multiple of 8.
        valid = (cfg_len != '0) && (cfg_len[2:0] == 3'b000);
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pb_frame_sequencer.sv
// Accepts one frame request, resolves L and walks the interleaver through num_pb blocks.
//   state  | meaning
//   IDLE   | ready for a request; rejects pulse err_req and stay here
//   LOOKUP | L and L/2 registered, pb_idx cleared
//   START  | pb_start pulse for the current PB
//   WAIT   | waiting for pb_done from the interleaver
//   DONE   | frame_done pulse, back to IDLE next cycle
module pb_frame_sequencer
  import pb_pkg::*;
#(
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned NPB_W     = 4,
  parameter int unsigned LEN_PB16  = LEN_PB16_DEF,
  parameter int unsigned LEN_PB136 = LEN_PB136_DEF,
  parameter int unsigned LEN_PB520 = LEN_PB520_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_pb_size,
  input  logic [NPB_W-1:0] req_num_pb,
  input  logic [LEN_W-1:0] cfg_len,
  output logic [LEN_W-1:0] len_l,
  output logic [LEN_W-1:0] len_half,
  output logic [NPB_W-1:0] pb_idx,
  output logic             pb_start,
  input  logic             pb_done,
  output logic             busy,
  output logic             frame_done,
  output logic             err_req
);

  pb_state_t        state_q, state_d;
  logic [LEN_W-1:0] lut_len;
  logic             lut_valid;
  logic [NPB_W-1:0] num_pb_q;
  logic             load, idx_inc, err_d;

  pb_len_lut #(
    .LEN_W     (LEN_W),
    .LEN_PB16  (LEN_PB16),
    .LEN_PB136 (LEN_PB136),
    .LEN_PB520 (LEN_PB520)
  ) u_len_lut (
    .code    (req_pb_size),
    .cfg_len (cfg_len),
    .len     (lut_len),
    .valid   (lut_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    idx_inc = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if ((req_num_pb != '0) && lut_valid) begin
            load    = 1'b1;
            state_d = LOOKUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOOKUP: state_d = START;
      START:  state_d = WAIT;
      WAIT: begin
        if (pb_done) begin
          if (pb_idx == num_pb_q - NPB_W'(1)) begin
            state_d = DONE;
          end else begin
            idx_inc = 1'b1;
            state_d = START;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The resolved length stands in for the latched size code and cfg_len.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_l    <= '0;
      len_half <= '0;
      num_pb_q <= '0;
      pb_idx   <= '0;
      err_req  <= 1'b0;
    end else begin
      err_req <= err_d;
      if (load) begin
        len_l    <= lut_len;
        len_half <= lut_len >> 1;
        num_pb_q <= req_num_pb;
        pb_idx   <= '0;
      end else if (idx_inc) begin
        pb_idx <= pb_idx + NPB_W'(1);
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign pb_start   = (state_q == START);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_pb_frame_sequencer.sv
// Directed bench for pb_frame_sequencer with hand-computed expectations.
module tb_pb_frame_sequencer;

  localparam int LEN_W = 12;
  localparam int NPB_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_pb_size;
  logic [NPB_W-1:0] req_num_pb;
  logic [LEN_W-1:0] cfg_len;
  logic [LEN_W-1:0] len_l;
  logic [LEN_W-1:0] len_half;
  logic [NPB_W-1:0] pb_idx;
  logic             pb_start;
  logic             pb_done;
  logic             busy;
  logic             frame_done;
  logic             err_req;

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  int n_fdone = 0;
  int s0, f0;

  pb_frame_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_pb_size (req_pb_size),
    .req_num_pb  (req_num_pb),
    .cfg_len     (cfg_len),
    .len_l       (len_l),
    .len_half    (len_half),
    .pb_idx      (pb_idx),
    .pb_start    (pb_start),
    .pb_done     (pb_done),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_req     (err_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pb_start)   n_start <= n_start + 1;
    if (frame_done) n_fdone <= n_fdone + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_pb_size = 2'd0; req_num_pb = '0;
    cfg_len = '0; pb_done = 1'b0;
    tick(2);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_len", 32'(len_l), 0);
    chk("rst_start", 32'(pb_start), 0);
    chk("rst_err", 32'(err_req), 0);
    rst = 1'b0;
    tick(1);

    // 1: PB520, one block
    req_valid = 1'b1; req_pb_size = 2'd2; req_num_pb = 4'd1;
    tick(1);
    req_valid = 1'b0;
    chk("t1_len", 32'(len_l), 2080);
    chk("t1_half", 32'(len_half), 1040);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(req_ready), 0);
    chk("t1_nostart", 32'(pb_start), 0);
    tick(1);
    chk("t1_start", 32'(pb_start), 1);
    chk("t1_idx", 32'(pb_idx), 0);
    tick(5);
    chk("t1_start_gone", 32'(pb_start), 0);
    pb_done = 1'b1;
    chk("t1_fd_early", 32'(frame_done), 0);
    tick(1);
    pb_done = 1'b0;
    chk("t1_fd", 32'(frame_done), 1);
    tick(1);
    chk("t1_fd_pulse", 32'(frame_done), 0);
    chk("t1_ready_back", 32'(req_ready), 1);
    chk("t1_len_hold", 32'(len_l), 2080);

    // 2: PB136, three blocks
    s0 = n_start;
    req_valid = 1'b1; req_pb_size = 2'd1; req_num_pb = 4'd3;
    tick(1);
    req_valid = 1'b0;
    chk("t2_len", 32'(len_l), 544);
    chk("t2_half", 32'(len_half), 272);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_start", 32'(pb_start), 1);
      chk("t2_idx", 32'(pb_idx), 32'(i));
      tick(4);
      chk("t2_fd_early", 32'(frame_done), 0);
      pb_done = 1'b1;
      tick(1);
      pb_done = 1'b0;
      chk("t2_len_hold", 32'(len_l), 544);
    end
    chk("t2_fd", 32'(frame_done), 1);
    chk("t2_nstart", 32'(n_start - s0), 3);
    tick(1);

    // 3a: custom length 40
    req_valid = 1'b1; req_pb_size = 2'd3; req_num_pb = 4'd1; cfg_len = 12'd40;
    tick(1);
    req_valid = 1'b0;
    chk("t3_len", 32'(len_l), 40);
    chk("t3_half", 32'(len_half), 20);
    tick(1);
    chk("t3_start", 32'(pb_start), 1);
    tick(1);
    pb_done = 1'b1;
    tick(1);
    pb_done = 1'b0;
    chk("t3_fd", 32'(frame_done), 1);
    tick(1);

    // 3b: custom length 44 is not a multiple of 8
    s0 = n_start;
    req_valid = 1'b1; req_pb_size = 2'd3; req_num_pb = 4'd2; cfg_len = 12'd44;
    tick(1);
    req_valid = 1'b0;
    chk("t3b_err", 32'(err_req), 1);
    chk("t3b_busy", 32'(busy), 0);
    tick(1);
    chk("t3b_err_pulse", 32'(err_req), 0);
    tick(3);
    chk("t3b_nostart", 32'(n_start - s0), 0);
    chk("t3b_len_keep", 32'(len_l), 40);

    // 3c: custom length 0
    req_valid = 1'b1; req_pb_size = 2'd3; req_num_pb = 4'd1; cfg_len = 12'd0;
    tick(1);
    req_valid = 1'b0;
    chk("t3c_err", 32'(err_req), 1);
    tick(1);

    // 4: zero PB count
    req_valid = 1'b1; req_pb_size = 2'd0; req_num_pb = 4'd0;
    tick(1);
    req_valid = 1'b0;
    chk("t4_err", 32'(err_req), 1);
    chk("t4_busy", 32'(busy), 0);
    tick(1);
    chk("t4_busy2", 32'(busy), 0);
    chk("t4_len_keep", 32'(len_l), 40);

    // 5: spurious pb_done in IDLE and alongside pb_start; req_valid held while busy
    s0 = n_start;
    pb_done = 1'b1;
    tick(2);
    pb_done = 1'b0;
    chk("t5_idle_idx", 32'(pb_idx), 0);
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_nostart", 32'(n_start - s0), 0);
    req_valid = 1'b1; req_pb_size = 2'd1; req_num_pb = 4'd2;
    tick(1);
    chk("t5_len", 32'(len_l), 544);
    req_pb_size = 2'd2;
    tick(1);
    chk("t5_start", 32'(pb_start), 1);
    pb_done = 1'b1;
    tick(1);
    pb_done = 1'b0;
    chk("t5_noadv", 32'(pb_idx), 0);
    chk("t5_busy_ready", 32'(req_ready), 0);
    tick(2);
    pb_done = 1'b1;
    tick(1);
    pb_done = 1'b0;
    chk("t5_idx1", 32'(pb_idx), 1);
    chk("t5_len_busy", 32'(len_l), 544);
    tick(2);
    pb_done = 1'b1;
    tick(1);
    pb_done = 1'b0;
    chk("t5_fd", 32'(frame_done), 1);
    tick(1);
    chk("t5_idle_ready", 32'(req_ready), 1);
    chk("t5_len_before", 32'(len_l), 544);
    tick(1);
    req_valid = 1'b0;
    chk("t5_reaccept", 32'(len_l), 2080);
    chk("t5_reaccept_busy", 32'(busy), 1);

    // 6: reset in WAIT with pb_idx=1
    tick(2);
    pb_done = 1'b1;
    tick(1);
    pb_done = 1'b0;
    tick(1);
    chk("t6_idx1", 32'(pb_idx), 1);
    f0 = n_fdone;
    rst = 1'b1;
    #2;
    chk("t6_idx", 32'(pb_idx), 0);
    chk("t6_len", 32'(len_l), 0);
    chk("t6_half", 32'(len_half), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ready", 32'(req_ready), 1);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("t6_nofd", 32'(n_fdone - f0), 0);
    req_valid = 1'b1; req_pb_size = 2'd0; req_num_pb = 4'd1;
    tick(1);
    req_valid = 1'b0;
    chk("t6_len64", 32'(len_l), 64);
    chk("t6_half32", 32'(len_half), 32);
    tick(1);
    chk("t6_start", 32'(pb_start), 1);
    tick(1);
    pb_done = 1'b1;
    tick(1);
    pb_done = 1'b0;
    chk("t6_fd", 32'(frame_done), 1);
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
